// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter family.
// Holds the FSM state encoding, index-width helpers and the one-hot encoder.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Upper bound on requester count; onehot() returns this width and callers slice.
  localparam int MAX_N     = 16;
  localparam int DEF_N     = 4;
  localparam int DEF_IDX_W = $clog2(DEF_N);

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAX_N-1:0] onehot(input int idx, input int n);
    logic [MAX_N-1:0] v;
    v = '0;
    if (idx >= 0 && idx < n) v = MAX_N'(1) << idx;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority encoder: first set bit of r at or after ptr, wrapping mod N.
// Reusable by multi-resource schedulers.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  r,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  always_comb begin
    int j;
    // NOTE: every output gets a default before the loop so no latch is inferred.
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!valid && r[j]) begin
        valid = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_timed.sv
// Round-robin arbiter with registered one-hot grant and a bounded hold time.
// Every release inserts one idle cycle before the next grant (bus turnaround).
module rr_arbiter_timed
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [N-1:0]         r,
  output logic [N-1:0]         g,
  output logic                 busy,
  output logic [$clog2(N)-1:0] gid,
  output logic                 timeout
);

  localparam int IW = $clog2(N);

  state_t           state, state_n;
  logic [IW-1:0]    ptr, ptr_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [N-1:0]     g_n;
  logic [IW-1:0]    gid_n;
  logic             busy_n;
  logic             timeout_n;

  logic             pick_valid;
  logic [IW-1:0]    pick_idx;
  logic [IW-1:0]    gid_inc;
  logic             hold_limit;
  logic [MAX_N-1:0] pick_oh;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .r     (r),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign gid_inc    = (gid == IW'(N - 1)) ? '0 : gid + 1'b1;
  assign hold_limit = (MAX_HOLD != 0) && (cnt == CNT_W'(MAX_HOLD));
  assign pick_oh    = onehot(int'(pick_idx), N);

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    cnt_n     = cnt;
    g_n       = g;
    gid_n     = gid;
    busy_n    = busy;
    timeout_n = 1'b0;

    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_n = GRANT;
          gid_n   = pick_idx;
          g_n     = pick_oh[N-1:0];
          busy_n  = 1'b1;
          cnt_n   = CNT_W'(1);
        end else begin
          g_n    = '0;
          busy_n = 1'b0;
        end
      end
      GRANT: begin
        // A dropped request outranks the hold limit, so a voluntary release never reports timeout.
        if (!r[gid] || hold_limit) begin
          state_n   = IDLE;
          g_n       = '0;
          busy_n    = 1'b0;
          ptr_n     = gid_inc;
          cnt_n     = '0;
          timeout_n = r[gid];
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        g_n     = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    if (Reset) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      g       <= '0;
      gid     <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      cnt     <= cnt_n;
      g       <= g_n;
      gid     <= gid_n;
      busy    <= busy_n;
      timeout <= timeout_n;
    end
  end

endmodule
